// File: rtl/conv_top_system.sv
// Serial 3x3 zero-padded conv engine: one MAC per accepted (act, weight) pair, one result per output.
// Latency N_MAC+1 cycles per output; con_valid may stall indefinitely, accumulator and tap counters hold.
module conv_top_system #(
  parameter int IO_DATA_WIDTH      = 16,
  parameter int ACCUMULATION_WIDTH = 32,
  parameter int EXT_MEM_HEIGHT     = 1 << 20,
  parameter int EXT_MEM_WIDTH      = 32,
  parameter int FEATURE_MAP_WIDTH  = 64,
  parameter int FEATURE_MAP_HEIGHT = 64,
  parameter int INPUT_NB_CHANNELS  = 4,
  parameter int OUTPUT_NB_CHANNELS = 32,
  parameter int KERNEL_SIZE        = 3
) (
  input  logic                     clk,
  input  logic                     arst_n_in,
  inout  wire  [IO_DATA_WIDTH-1:0] con_1,
  inout  wire  [IO_DATA_WIDTH-1:0] con_2,
  inout  wire  [IO_DATA_WIDTH-1:0] con_3,
  input  logic                     con_valid,
  output logic                     con_ready,
  output logic                     output_valid,
  output logic [5:0]               output_x,
  output logic [5:0]               output_y,
  output logic [4:0]               output_ch,
  input  logic                     start,
  output logic                     running,
  output logic                     driving_cons,
  output logic                     last_load_K
);

  localparam int PAD = (KERNEL_SIZE - 1) / 2;
  localparam int KW  = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int CIW = (INPUT_NB_CHANNELS > 1) ? $clog2(INPUT_NB_CHANNELS) : 1;

  if (EXT_MEM_HEIGHT < 1 || EXT_MEM_WIDTH < 1 || FEATURE_MAP_WIDTH > 64 || FEATURE_MAP_HEIGHT > 64 ||
      OUTPUT_NB_CHANNELS > 32 || ACCUMULATION_WIDTH != 2 * IO_DATA_WIDTH) begin : g_param_check
    $error("conv_top_system: unsupported parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t                        state;
  logic [KW-1:0]                 ky, kx;
  logic [CIW-1:0]                ci;
  logic [ACCUMULATION_WIDTH-1:0] acc;
  logic signed [ACCUMULATION_WIDTH-1:0] prod;

  // Valid kernel rows/cols form a rectangle, so skipped taps cost no cycles.
  function automatic logic [KW-1:0] tap_lo(input logic [5:0] c);
    int v;
    v = PAD - int'(c);
    if (v < 0) v = 0;
    return KW'(v);
  endfunction

  function automatic logic [KW-1:0] tap_hi(input logic [5:0] c, input int size);
    int v;
    v = size - 1 + PAD - int'(c);
    if (v > KERNEL_SIZE - 1) v = KERNEL_SIZE - 1;
    return KW'(v);
  endfunction

  logic [KW-1:0] ky_lo, ky_hi, kx_lo, kx_hi;
  logic          first_tap, last_tap, last_out;
  logic [5:0]    nxt_x, nxt_y;
  logic [4:0]    nxt_ch;

  assign ky_lo = tap_lo(output_y);
  assign kx_lo = tap_lo(output_x);
  assign ky_hi = tap_hi(output_y, FEATURE_MAP_HEIGHT);
  assign kx_hi = tap_hi(output_x, FEATURE_MAP_WIDTH);

  assign first_tap = (ky == ky_lo) && (kx == kx_lo) && (ci == '0);
  assign last_tap  = (ky == ky_hi) && (kx == kx_hi) && (ci == CIW'(INPUT_NB_CHANNELS - 1));
  assign last_out  = (output_ch == 5'(OUTPUT_NB_CHANNELS - 1)) &&
                     (output_x == 6'(FEATURE_MAP_WIDTH - 1)) &&
                     (output_y == 6'(FEATURE_MAP_HEIGHT - 1));

  always_comb begin
    nxt_x  = output_x;
    nxt_y  = output_y;
    nxt_ch = output_ch + 5'd1;
    if (output_ch == 5'(OUTPUT_NB_CHANNELS - 1)) begin
      nxt_ch = '0;
      if (output_x == 6'(FEATURE_MAP_WIDTH - 1)) begin
        nxt_x = '0;
        nxt_y = output_y + 6'd1;
      end else begin
        nxt_x = output_x + 6'd1;
      end
    end
  end

  assign prod        = ACCUMULATION_WIDTH'($signed(con_1)) * ACCUMULATION_WIDTH'($signed(con_2));
  assign last_load_K = con_ready && last_tap;

  assign con_1 = driving_cons ? acc[ACCUMULATION_WIDTH-1 -: IO_DATA_WIDTH] : 'z;
  assign con_2 = driving_cons ? acc[IO_DATA_WIDTH-1:0] : 'z;
  assign con_3 = driving_cons ? '0 : 'z;

  always_ff @(posedge clk) begin
    if (arst_n_in) begin
      state        <= S_IDLE;
      con_ready    <= 1'b0;
      output_valid <= 1'b0;
      driving_cons <= 1'b0;
      running      <= 1'b0;
      output_x     <= '0;
      output_y     <= '0;
      output_ch    <= '0;
      acc          <= '0;
      ky           <= '0;
      kx           <= '0;
      ci           <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_MAC;
            running   <= 1'b1;
            con_ready <= 1'b1;
            output_x  <= '0;
            output_y  <= '0;
            output_ch <= '0;
            ky        <= tap_lo(6'd0);
            kx        <= tap_lo(6'd0);
            ci        <= '0;
          end
        end
        S_MAC: begin
          if (con_valid) begin
            acc <= first_tap ? prod : acc + prod;
            if (last_tap) begin
              state        <= S_OUT;
              con_ready    <= 1'b0;
              output_valid <= 1'b1;
              driving_cons <= 1'b1;
            end else if (ci == CIW'(INPUT_NB_CHANNELS - 1)) begin
              ci <= '0;
              if (kx == kx_hi) begin
                kx <= kx_lo;
                ky <= ky + 1'b1;
              end else begin
                kx <= kx + 1'b1;
              end
            end else begin
              ci <= ci + 1'b1;
            end
          end
        end
        S_OUT: begin
          output_valid <= 1'b0;
          driving_cons <= 1'b0;
          if (last_out) begin
            state   <= S_IDLE;
            running <= 1'b0;
          end else begin
            state     <= S_MAC;
            con_ready <= 1'b1;
            output_x  <= nxt_x;
            output_y  <= nxt_y;
            output_ch <= nxt_ch;
            ky        <= tap_lo(nxt_y);
            kx        <= tap_lo(nxt_x);
            ci        <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_top_system.sv
// Directed bench on a reduced 4x3 map, 4 input / 2 output channels; scoreboard of per-output dot products.
module tb_conv_top_system;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int CI = 4;
  localparam int OC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        con_valid = 1'b0;
  logic        tb_en = 1'b0;
  logic [15:0] tb_act = '0;
  logic [15:0] tb_w = '0;
  wire  [15:0] con_1, con_2, con_3;
  logic        con_ready, output_valid, running, driving_cons, last_load_K;
  logic [5:0]  output_x, output_y;
  logic [4:0]  output_ch;

  assign con_1 = (tb_en && !driving_cons) ? tb_act : 16'hzzzz;
  assign con_2 = (tb_en && !driving_cons) ? tb_w : 16'hzzzz;

  conv_top_system #(
    .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H),
    .INPUT_NB_CHANNELS(CI), .OUTPUT_NB_CHANNELS(OC)
  ) dut (
    .clk(clk), .arst_n_in(rst),
    .con_1(con_1), .con_2(con_2), .con_3(con_3),
    .con_valid(con_valid), .con_ready(con_ready), .output_valid(output_valid),
    .output_x(output_x), .output_y(output_y), .output_ch(output_ch),
    .start(start), .running(running), .driving_cons(driving_cons), .last_load_K(last_load_K)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int ch;
    int acc;
    int pairs;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   out_xfers = 0;
  logic mon_en = 1'b0;
  logic idle_next = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (!con_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!con_ready) begin
      checks++;
      errors++;
      $display("FAIL con_ready_timeout actual=0 required=1");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "handshake bound expired");
    end
  endtask

  function automatic bit in_map(input int px, input int py);
    return (px >= 0) && (px < W) && (py >= 0) && (py < H);
  endfunction

  // Streams every in-bounds tap of one output and records the expected dot product.
  task automatic do_output(input int x, input int y, input int ch);
    int          n, idx, acc;
    logic [15:0] a, w;
    exp_t        e;
    n = 0;
    for (int ky = 0; ky < 3; ky++)
      for (int kx = 0; kx < 3; kx++)
        if (in_map(x + kx - 1, y + ky - 1)) n += CI;
    idx = 0;
    acc = 0;
    for (int ky = 0; ky < 3; ky++) begin
      for (int kx = 0; kx < 3; kx++) begin
        if (!in_map(x + kx - 1, y + ky - 1)) continue;
        for (int c = 0; c < CI; c++) begin
          if (x == 0 && y == 0 && ch == 0) begin
            a = 16'd1; w = 16'd1;
          end else if (x == 1 && y == 1 && ch == 0) begin
            a = 16'd2; w = 16'hFFFD;
          end else if (x == 1 && y == 1 && ch == 1) begin
            a = 16'h7FFF; w = 16'h7FFF;
          end else begin
            a = 16'($urandom); w = 16'($urandom);
          end
          if (x == 2 && y == 1 && ch == 0 && idx == 10) begin
            con_valid = 1'b0;
            repeat (5) @(negedge clk);
            chk("stall_no_output", {31'd0, output_valid}, 32'd0);
          end
          con_valid = 1'b1;
          tb_act    = a;
          tb_w      = w;
          tb_en     = 1'b1;
          wait_ready();
          chk("last_load_K", {31'd0, last_load_K}, {31'd0, idx == n - 1});
          acc = acc + int'($signed(a)) * int'($signed(w));
          idx++;
          out_xfers++;
          if (idx == n) begin
            e.x = x; e.y = y; e.ch = ch; e.acc = acc; e.pairs = n;
            expq.push_back(e);
          end
          @(negedge clk);
          start = 1'b0;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] res;
    if (mon_en && !rst) begin
      chk("drive_eq_valid", {31'd0, driving_cons}, {31'd0, output_valid});
      chk("ready_rule", {31'd0, con_ready}, {31'd0, running && !output_valid});
      if (idle_next) begin
        chk("running_fall", {31'd0, running}, 32'd0);
        idle_next = 1'b0;
      end
      if (output_valid) begin
        if (expq.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          e   = expq.pop_front();
          res = {con_1, con_2};
          chk("out_x", {26'd0, output_x}, e.x);
          chk("out_y", {26'd0, output_y}, e.y);
          chk("out_ch", {27'd0, output_ch}, e.ch);
          chk("result", res, e.acc);
          chk("con_3", {16'd0, con_3}, 32'd0);
          chk("pair_count", out_xfers, e.pairs);
          if (e.x == 0 && e.y == 0 && e.ch == 0) begin
            chk("corner_lit", res, 32'h0000_0010);
            chk("corner_pairs", e.pairs, 32'd16);
          end
          if (e.x == 1 && e.y == 0 && e.ch == 0) chk("edge_pairs", e.pairs, 32'd24);
          if (e.x == 1 && e.y == 1 && e.ch == 0) begin
            chk("interior_lit", res, 32'hFFFF_FF28);
            chk("interior_pairs", e.pairs, 32'd36);
          end
          if (e.x == 1 && e.y == 1 && e.ch == 1) chk("wrap_lit", res, 32'hFFDC_0024);
          if (e.x == W - 1 && e.y == H - 1 && e.ch == OC - 1) idle_next = 1'b1;
        end
        out_xfers = 0;
      end
    end
  end

  task automatic drain_and_check_idle(input string tag);
    for (int t = 0; t < 20 && expq.size() > 0; t++) @(negedge clk);
    chk({tag, "_drained"}, expq.size(), 32'd0);
    repeat (2) @(negedge clk);
    chk({tag, "_idle_running"}, {31'd0, running}, 32'd0);
    chk({tag, "_idle_ready"}, {31'd0, con_ready}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks + 1, errors + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, con_ready}, 32'd0);
    chk("rst_valid", {31'd0, output_valid}, 32'd0);
    chk("rst_driving", {31'd0, driving_cons}, 32'd0);
    chk("rst_running", {31'd0, running}, 32'd0);
    chk("rst_last", {31'd0, last_load_K}, 32'd0);
    chk("rst_coords", {15'd0, output_x, output_y, output_ch}, 32'd0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Full layer; a second start pulse lands mid-run and must be ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_running", {31'd0, running}, 32'd1);
    chk("start_ready", {31'd0, con_ready}, 32'd1);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        for (int ch = 0; ch < OC; ch++) begin
          if (y == 0 && x == 1 && ch == 1) start = 1'b1;
          do_output(x, y, ch);
        end
    con_valid = 1'b0;
    tb_en     = 1'b0;
    drain_and_check_idle("run");

    // Reset in the middle of an output: no result, back to idle.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      con_valid = 1'b1; tb_act = 16'd9; tb_w = 16'd9; tb_en = 1'b1;
      wait_ready();
      @(negedge clk);
    end
    rst       = 1'b1;
    con_valid = 1'b0;
    tb_en     = 1'b0;
    @(negedge clk);
    rst       = 1'b0;
    out_xfers = 0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_running", {31'd0, running}, 32'd0);
      chk("abort_valid", {31'd0, output_valid}, 32'd0);
    end

    // Restart after the abort must produce a clean first output.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    do_output(0, 0, 0);
    con_valid = 1'b0;
    tb_en     = 1'b0;
    for (int t = 0; t < 20 && expq.size() > 0; t++) @(negedge clk);
    chk("restart_drained", expq.size(), 32'd0);
    @(negedge clk);
    mon_en = 1'b0;
    rst    = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_top_system.md
# conv_top_system

Serial 2D-convolution engine computing one output pixel of a 3×3, zero-padded, same-size convolution at a time. The feature map is 64×64×4 and there are 32 output channels. The testbench streams (activation, weight) pairs over the shared `con_*` buses with a valid/ready handshake. The engine multiply-accumulates each pair and drives each 32-bit result back on the same buses with its coordinates. It is the top of the accelerator.

## Interface
- `IO_DATA_WIDTH`, default 16: activation/weight width, signed.
- `ACCUMULATION_WIDTH`, default 32: accumulator and result width, signed.
- `EXT_MEM_HEIGHT`, default 1<<20: external memory depth. Unused inside this block; kept for compatibility.
- `EXT_MEM_WIDTH`, default 32: external memory width. Unused inside this block.
- `FEATURE_MAP_WIDTH`, default 64: X size.
- `FEATURE_MAP_HEIGHT`, default 64: Y size.
- `INPUT_NB_CHANNELS`, default 4: input channels per MAC sweep.
- `OUTPUT_NB_CHANNELS`, default 32: output channels.
- `KERNEL_SIZE`, default 3: kernel edge length. Padding is (K-1)/2 = 1.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `arst_n_in`, in, 1: reset, synchronous, active-high. Despite the `_n` in the name, the block resets while this is 1.
- `con_1`, inout, 16: activation in during MAC; result[31:16] out during output.
- `con_2`, inout, 16: weight in during MAC; result[15:0] out during output.
- `con_3`, inout, 16: ignored on input; driven 0 during output.
- `con_valid`, in, 1: testbench has a valid pair on `con_1`/`con_2`.
- `con_ready`, out, 1: block accepts a pair this cycle.
- `output_valid`, out, 1: result present on the `con_*` buses.
- `output_x`, out, 6: X of the result.
- `output_y`, out, 6: Y of the result.
- `output_ch`, out, 5: output channel of the result.
- `start`, in, 1: begin a full-layer run.
- `running`, out, 1: a run is in progress.
- `driving_cons`, out, 1: block is driving `con_1..3`. When 0, all three are high-Z.
- `last_load_K`, out, 1: the current handshake slot is the final MAC of the current output.

## Operation
States and transitions:
- IDLE → MAC when `start`=1.
- MAC → OUT on the last accepted pair of the current output.
- OUT → MAC if more outputs remain.
- OUT → IDLE after (x=63, y=63, ch=31).

Loop order:
- Outer loops: y 0..63, then x 0..63, then ch 0..31.
- Inner loops per output: ky 0..2, then kx 0..2, then ci 0..3.
- Kernel taps whose input position (x+kx-1, y+ky-1) lies outside 0..63 are skipped entirely. No handshake occurs for them.
- MAC count per output: interior 36, edge 24, corner 16.

Arithmetic:
- Product = signed 16×16 → 32 bits.
- First pair of an output: acc = product. Every later pair: acc = acc + product, modulo 2^32, with no saturation.

Output:
- `con_1` = acc[31:16], `con_2` = acc[15:0], `con_3` = 0.
- `output_x`/`output_y`/`output_ch` hold the output's coordinates.

`running` is 1 in MAC and OUT, and 0 in IDLE. `start` is ignored while `running`=1.

## Timing
- Reset values: `con_ready`=0, `output_valid`=0, `driving_cons`=0, `running`=0, `last_load_K`=0, `output_x`/`output_y`/`output_ch`=0, accumulator 0, state IDLE.
- Reset mid-run aborts immediately with no partial output. A new `start` is then required.
- `running` and `con_ready` go high the cycle after `start` is sampled.
- MAC state:
  - `con_ready`=1 throughout.
  - A transfer occurs on each edge where `con_valid` && `con_ready`. There is no limit on stall length.
  - `last_load_K`=1 while waiting for and accepting the final pair of the output.
- OUT state:
  - Entered on the edge after the final transfer and lasts exactly 1 cycle.
  - In that cycle: `output_valid`=1, `driving_cons`=1, `con_ready`=0.
- The next output's MAC starts the following cycle. Per-output latency with no stalls is N_MAC + 1 cycles.
- The multiply plus add fits in one clock cycle. There is no pipelining.

## Test plan
- Reset: assert `arst_n_in` for 2 cycles → all outputs 0, `con_1..3` high-Z.
- Corner (0,0), ch 0, act=1, w=1:
  - Exactly 16 handshakes, with `last_load_K` high only on the 16th.
  - Then `output_valid` for 1 cycle with `con_1`=0x0000, `con_2`=0x0010, x=0, y=0, ch=0.
- Interior (1,1), act=2, w=-3 for all 36 pairs → result -216: `con_1`=0xFFFF, `con_2`=0xFF28.
- Wrap-around: interior output, act=w=0x7FFF for all 36 pairs → result 0xFFDC0024 (`con_1`=0xFFDC, `con_2`=0x0024).
- Backpressure: drop `con_valid` for 5 cycles mid-sweep → the accumulator holds and the result equals the unstalled result.
- Full run with random data:
  - 131072 `output_valid` pulses in y/x/ch order, each matching the reference model.
  - `running` falls the cycle after output (63,63,31).
  - A `start` during the run has no effect.
